// File: rtl/control_configuracion_pkg.sv
// Shared encodings for the configuration controller and the register chip-select decoder.
package control_configuracion_pkg;

  typedef enum logic [1:0] {
    StReposo     = 2'b00,
    StSelFuncion = 2'b01,
    StEdicion    = 2'b10
  } estado_e;

  typedef enum logic [1:0] {
    FuncNinguna = 2'b00,
    FuncHora    = 2'b01,
    FuncFecha   = 2'b10,
    FuncTimer   = 2'b11
  } funcion_e;

  // Field index within a group: seg/dia, min/mes, hora/jahr.
  typedef enum logic [1:0] {
    CampoSeg  = 2'b00,
    CampoMin  = 2'b01,
    CampoHora = 2'b10
  } campo_e;

  typedef enum logic [2:0] {
    EvNinguno,
    EvProgramar,
    EvAceptar,
    EvCambio,
    EvDerecha,
    EvIzquierda,
    EvArriba,
    EvAbajo
  } evento_e;

  // Button flank vector order, highest priority first.
  localparam int unsigned IdxProgramar = 0;
  localparam int unsigned IdxAceptar   = 1;
  localparam int unsigned IdxCambio    = 2;
  localparam int unsigned IdxDerecha   = 3;
  localparam int unsigned IdxIzquierda = 4;
  localparam int unsigned IdxArriba    = 5;
  localparam int unsigned IdxAbajo     = 6;
  localparam int unsigned NumBotones   = 7;

  function automatic evento_e evento_prioritario(logic [NumBotones-1:0] flanco);
    evento_e ev;
    ev = EvNinguno;
    if (flanco[IdxProgramar])      ev = EvProgramar;
    else if (flanco[IdxAceptar])   ev = EvAceptar;
    else if (flanco[IdxCambio])    ev = EvCambio;
    else if (flanco[IdxDerecha])   ev = EvDerecha;
    else if (flanco[IdxIzquierda]) ev = EvIzquierda;
    else if (flanco[IdxArriba])    ev = EvArriba;
    else if (flanco[IdxAbajo])     ev = EvAbajo;
    return ev;
  endfunction

  // Group selection never returns to NINGUNA while cycling.
  function automatic logic [1:0] funcion_siguiente(logic [1:0] f);
    logic [1:0] r;
    case (f)
      FuncHora:  r = FuncFecha;
      FuncFecha: r = FuncTimer;
      default:   r = FuncHora;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] campo_siguiente(logic [1:0] c);
    logic [1:0] r;
    case (c)
      CampoSeg: r = CampoMin;
      CampoMin: r = CampoHora;
      default:  r = CampoSeg;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] campo_anterior(logic [1:0] c);
    logic [1:0] r;
    case (c)
      CampoHora: r = CampoMin;
      CampoMin:  r = CampoSeg;
      default:   r = CampoHora;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for a debounced button level; pulso is high on the first sampled-high cycle.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic nivel,
  output logic pulso
);

  logic nivel_q;

  always_ff @(posedge clk) begin
    if (reset) nivel_q <= 1'b0;
    else       nivel_q <= nivel;
  end

  assign pulso = nivel & ~nivel_q;

endmodule

// File: rtl/control_configuracion.sv
// Button-driven configuration controller: group selection, field editing, inc/dec strobes
// and an inactivity timeout back to idle.
module control_configuracion
  import control_configuracion_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_programar,
  input  logic       btn_cambio,
  input  logic       btn_aceptar,
  input  logic       btn_derecha,
  input  logic       btn_izquierda,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic [1:0] funcion_conf,
  output logic [1:0] campo_sel,
  output logic       pulso_incr,
  output logic       pulso_decr,
  output logic       modo_config,
  output logic       fin_timeout
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CICLOS - 1);
  localparam logic [CntWidth-1:0] CntUno = CntWidth'(1);

  logic [NumBotones-1:0] nivel;
  logic [NumBotones-1:0] flanco;
  evento_e               evento;
  logic                  hay_evento;
  estado_e               estado_q;
  logic [CntWidth-1:0]   cnt_q;

  always_comb begin
    nivel               = '0;
    nivel[IdxProgramar] = btn_programar;
    nivel[IdxAceptar]   = btn_aceptar;
    nivel[IdxCambio]    = btn_cambio;
    nivel[IdxDerecha]   = btn_derecha;
    nivel[IdxIzquierda] = btn_izquierda;
    nivel[IdxArriba]    = btn_arriba;
    nivel[IdxAbajo]     = btn_abajo;
  end

  for (genvar i = 0; i < NumBotones; i++) begin : g_detector
    detector_flanco u_detector (
      .clk   (clk),
      .reset (reset),
      .nivel (nivel[i]),
      .pulso (flanco[i])
    );
  end

  always_comb begin
    evento     = evento_prioritario(flanco);
    hay_evento = |flanco;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= StReposo;
      cnt_q        <= '0;
      funcion_conf <= FuncNinguna;
      campo_sel    <= CampoSeg;
      pulso_incr   <= 1'b0;
      pulso_decr   <= 1'b0;
      modo_config  <= 1'b0;
      fin_timeout  <= 1'b0;
    end else begin
      pulso_incr  <= 1'b0;
      pulso_decr  <= 1'b0;
      fin_timeout <= 1'b0;

      if (estado_q == StReposo) begin
        cnt_q <= '0;
        if (evento == EvProgramar) begin
          estado_q     <= StSelFuncion;
          funcion_conf <= FuncHora;
          campo_sel    <= CampoSeg;
          modo_config  <= 1'b1;
        end
      end else if (!hay_evento) begin
        // Timeout only fires in a cycle with no button event at all.
        if (cnt_q == CntMax) begin
          estado_q     <= StReposo;
          funcion_conf <= FuncNinguna;
          campo_sel    <= CampoSeg;
          modo_config  <= 1'b0;
          fin_timeout  <= 1'b1;
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_q + CntUno;
        end
      end else begin
        cnt_q <= '0;
        if (evento == EvProgramar) begin
          estado_q     <= StReposo;
          funcion_conf <= FuncNinguna;
          campo_sel    <= CampoSeg;
          modo_config  <= 1'b0;
        end else if (estado_q == StSelFuncion) begin
          case (evento)
            EvAceptar: begin
              estado_q  <= StEdicion;
              campo_sel <= CampoSeg;
            end
            EvCambio: funcion_conf <= funcion_siguiente(funcion_conf);
            default: ;
          endcase
        end else if (estado_q == StEdicion) begin
          case (evento)
            EvDerecha:   campo_sel  <= campo_siguiente(campo_sel);
            EvIzquierda: campo_sel  <= campo_anterior(campo_sel);
            EvArriba:    pulso_incr <= 1'b1;
            EvAbajo:     pulso_decr <= 1'b1;
            default: ;
          endcase
        end else begin
          // Unreachable encoding: recover to idle.
          estado_q     <= StReposo;
          funcion_conf <= FuncNinguna;
          campo_sel    <= CampoSeg;
          modo_config  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_configuracion.sv
// Directed bench for control_configuracion with TIMEOUT_CICLOS = 20.
module tb_control_configuracion;

  localparam int unsigned Timeout = 20;

  // Bench button vector bit order.
  localparam logic [6:0] BProg = 7'b000_0001;
  localparam logic [6:0] BCamb = 7'b000_0010;
  localparam logic [6:0] BAcep = 7'b000_0100;
  localparam logic [6:0] BDer  = 7'b000_1000;
  localparam logic [6:0] BIzq  = 7'b001_0000;
  localparam logic [6:0] BArr  = 7'b010_0000;
  localparam logic [6:0] BAba  = 7'b100_0000;

  logic       clk;
  logic       reset;
  logic [6:0] btn;
  logic [1:0] funcion_conf;
  logic [1:0] campo_sel;
  logic       pulso_incr;
  logic       pulso_decr;
  logic       modo_config;
  logic       fin_timeout;

  int total;
  int bad;
  int n_incr;

  control_configuracion #(
    .TIMEOUT_CICLOS (Timeout)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_programar (btn[0]),
    .btn_cambio    (btn[1]),
    .btn_aceptar   (btn[2]),
    .btn_derecha   (btn[3]),
    .btn_izquierda (btn[4]),
    .btn_arriba    (btn[5]),
    .btn_abajo     (btn[6]),
    .funcion_conf  (funcion_conf),
    .campo_sel     (campo_sel),
    .pulso_incr    (pulso_incr),
    .pulso_decr    (pulso_decr),
    .modo_config   (modo_config),
    .fin_timeout   (fin_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input int obs, input int esp);
    total++;
    if (obs != esp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then the mask is high for exactly one edge; outputs of that edge are visible.
  task automatic pulsar(input logic [6:0] mask);
    tick();
    btn = mask;
    tick();
    btn = '0;
  endtask

  task automatic comprobar_todo_cero(input string tag);
    comprobar({tag, "_funcion"}, int'(funcion_conf), 0);
    comprobar({tag, "_campo"}, int'(campo_sel), 0);
    comprobar({tag, "_modo"}, int'(modo_config), 0);
    comprobar({tag, "_incr"}, int'(pulso_incr), 0);
    comprobar({tag, "_decr"}, int'(pulso_decr), 0);
    comprobar({tag, "_timeout"}, int'(fin_timeout), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    btn   = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    comprobar_todo_cero("reset");

    // Events other than programar are ignored in idle.
    pulsar(BArr | BCamb);
    comprobar("reposo_ign_incr", int'(pulso_incr), 0);
    comprobar("reposo_ign_modo", int'(modo_config), 0);
    comprobar("reposo_ign_func", int'(funcion_conf), 0);

    // Enter selection and cycle groups.
    pulsar(BProg);
    comprobar("prog_funcion", int'(funcion_conf), 1);
    comprobar("prog_modo", int'(modo_config), 1);
    pulsar(BCamb);
    comprobar("cambio1", int'(funcion_conf), 2);
    pulsar(BCamb);
    comprobar("cambio2", int'(funcion_conf), 3);
    pulsar(BCamb);
    comprobar("cambio3_wrap", int'(funcion_conf), 1);
    pulsar(BArr);
    comprobar("sel_ign_incr", int'(pulso_incr), 0);
    pulsar(BProg);
    comprobar("salir_funcion", int'(funcion_conf), 0);
    comprobar("salir_modo", int'(modo_config), 0);

    // Group fecha, edit fields.
    pulsar(BProg);
    pulsar(BCamb);
    pulsar(BAcep);
    comprobar("acep_funcion", int'(funcion_conf), 2);
    comprobar("acep_campo", int'(campo_sel), 0);
    pulsar(BDer);
    comprobar("der1", int'(campo_sel), 1);
    pulsar(BDer);
    comprobar("der2", int'(campo_sel), 2);
    pulsar(BDer);
    comprobar("der3_wrap", int'(campo_sel), 0);
    pulsar(BIzq);
    comprobar("izq1_wrap", int'(campo_sel), 2);
    comprobar("edic_funcion", int'(funcion_conf), 2);

    // Held arriba gives exactly one strobe.
    tick();
    btn    = BArr;
    n_incr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) comprobar("arriba_primero", int'(pulso_incr), 1);
      n_incr += int'(pulso_incr);
    end
    btn = '0;
    comprobar("arriba_mantenido", n_incr, 1);

    // Simultaneous arriba/abajo: incr wins.
    pulsar(BArr | BAba);
    comprobar("simul_incr", int'(pulso_incr), 1);
    comprobar("simul_decr", int'(pulso_decr), 0);
    tick();
    comprobar("incr_un_ciclo", int'(pulso_incr), 0);
    pulsar(BAba);
    comprobar("abajo_decr", int'(pulso_decr), 1);
    comprobar("abajo_incr", int'(pulso_incr), 0);

    // Programar beats derecha.
    pulsar(BProg | BDer);
    comprobar("prog_der_modo", int'(modo_config), 0);
    comprobar("prog_der_campo", int'(campo_sel), 0);
    comprobar("prog_der_func", int'(funcion_conf), 0);

    // Timeout after exactly Timeout quiet cycles in selection.
    pulsar(BProg);
    for (int i = 1; i < Timeout; i++) tick();
    comprobar("pre_timeout_fin", int'(fin_timeout), 0);
    comprobar("pre_timeout_modo", int'(modo_config), 1);
    tick();
    comprobar("timeout_fin", int'(fin_timeout), 1);
    comprobar("timeout_funcion", int'(funcion_conf), 0);
    comprobar("timeout_modo", int'(modo_config), 0);
    tick();
    comprobar("timeout_un_ciclo", int'(fin_timeout), 0);

    // Event on the would-be timeout edge suppresses it and restarts the count.
    pulsar(BProg);
    for (int i = 1; i < Timeout; i++) tick();
    btn = BCamb;
    tick();
    btn = '0;
    comprobar("supr_fin", int'(fin_timeout), 0);
    comprobar("supr_funcion", int'(funcion_conf), 2);
    comprobar("supr_modo", int'(modo_config), 1);
    for (int i = 1; i < Timeout; i++) tick();
    comprobar("reinicio_pre_fin", int'(fin_timeout), 0);
    tick();
    comprobar("reinicio_fin", int'(fin_timeout), 1);

    // Reset during a decrement strobe clears everything.
    pulsar(BProg);
    pulsar(BAcep);
    tick();
    btn = BAba;
    tick();
    comprobar("pre_reset_decr", int'(pulso_decr), 1);
    btn   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    comprobar_todo_cero("reset_en_decr");

    // Programar held through reset release yields one event.
    reset = 1'b1;
    btn   = BProg;
    tick();
    reset = 1'b0;
    comprobar("reset_mantenido_func", int'(funcion_conf), 0);
    tick();
    comprobar("post_reset_evento", int'(funcion_conf), 1);
    tick();
    comprobar("post_reset_una_vez", int'(modo_config), 1);
    btn = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
